// File: rtl/instr_feeder.sv
// rtl/instr_feeder.sv - program sequencer driving DIN/Run of the 9-bit multicycle processor
// Optional single-step mode: define FEEDER_SINGLE_STEP_EN to add the Step input and STEP state.
module instr_feeder #(
  parameter int ADDR_W = 5,
  parameter int WORD_W = 9
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic [ADDR_W-1:0] LastAddr,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [WORD_W-1:0] WrData,
  input  logic              ProcDone,
`ifdef FEEDER_SINGLE_STEP_EN
  input  logic              Step,
`endif
  output logic [WORD_W-1:0] DOUT,
  output logic              Run,
  output logic              Busy,
  output logic              Halted,
  output logic [7:0]        InstrCount
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [2:0] OP_MVI = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DATA  = 3'd2,
`ifdef FEEDER_SINGLE_STEP_EN
    S_STEP  = 3'd4,
`endif
    S_WAIT  = 3'd3
  } state_t;

  state_t state, state_next;

  logic [WORD_W-1:0] mem [0:DEPTH-1];
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus1;
  logic [WORD_W-1:0] cur_word;
  logic              is_mvi;
  logic [ADDR_W:0]   len_w;
  logic [ADDR_W:0]   pc_sum;
  logic              halt;
  logic              complete;
  logic              start_ok;

  // Memory is frozen while busy, so mem[pc] still identifies the current instruction in DATA/WAIT.
  assign cur_word = mem[pc];
  assign is_mvi   = (cur_word[WORD_W-1 -: 3] == OP_MVI);
  assign pc_plus1 = pc + ADDR_W'(1);
  assign len_w    = is_mvi ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1);
  assign pc_sum   = {1'b0, pc} + len_w;
  assign halt     = (pc_sum > {1'b0, LastAddr});
  assign start_ok = (state == S_IDLE) && Start;

  always_ff @(posedge Clock) begin
    if (state == S_IDLE && WrEn) begin
      mem[WrAddr] <= WrData;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    Run        = 1'b0;
    DOUT       = '0;
    Busy       = 1'b1;
    complete   = 1'b0;
    case (state)
      S_IDLE: begin
        Busy = 1'b0;
        if (Start) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        Run        = 1'b1;
        DOUT       = cur_word;
        state_next = is_mvi ? S_DATA : S_WAIT;
      end
      S_DATA: begin
        DOUT = mem[pc_plus1];
        if (ProcDone) complete = 1'b1;
        else          state_next = S_WAIT;
      end
      S_WAIT: begin
        if (ProcDone) complete = 1'b1;
      end
`ifdef FEEDER_SINGLE_STEP_EN
      S_STEP: begin
        if (Step) state_next = S_ISSUE;
      end
`endif
      default: begin
        state_next = S_IDLE;
      end
    endcase
    if (complete) begin
`ifdef FEEDER_SINGLE_STEP_EN
      state_next = halt ? S_IDLE : S_STEP;
`else
      state_next = halt ? S_IDLE : S_ISSUE;
`endif
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pc         <= '0;
      InstrCount <= '0;
      Halted     <= 1'b0;
    end else if (start_ok) begin
      pc         <= '0;
      InstrCount <= '0;
      Halted     <= 1'b0;
    end else if (complete) begin
      pc         <= pc_sum[ADDR_W-1:0];
      InstrCount <= InstrCount + 8'd1;
      if (halt) Halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_feeder.sv
// tb/tb_instr_feeder.sv - directed self-checking bench for instr_feeder
module tb_instr_feeder;

  logic       Clock;
  logic       Resetn;
  logic       Start;
  logic [4:0] LastAddr;
  logic       WrEn;
  logic [4:0] WrAddr;
  logic [8:0] WrData;
  logic       ProcDone;
  logic       Step;
  logic [8:0] DOUT;
  logic       Run;
  logic       Busy;
  logic       Halted;
  logic [7:0] InstrCount;

  int vectors;
  int miscompares;

  instr_feeder #(.ADDR_W(5), .WORD_W(9)) dut (
    .Clock(Clock),
    .Resetn(Resetn),
    .Start(Start),
    .LastAddr(LastAddr),
    .WrEn(WrEn),
    .WrAddr(WrAddr),
    .WrData(WrData),
    .ProcDone(ProcDone),
`ifdef FEEDER_SINGLE_STEP_EN
    .Step(Step),
`endif
    .DOUT(DOUT),
    .Run(Run),
    .Busy(Busy),
    .Halted(Halted),
    .InstrCount(InstrCount)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One processor cycle: drive Done, check feeder outputs, advance past the edge.
  task automatic step(input logic done, input logic erun, input logic [8:0] edout,
                      input logic ebusy, input string tag);
    ProcDone = done;
    #1;
    check({tag, " Run"}, 32'(Run), 32'(erun));
    check({tag, " DOUT"}, 32'(DOUT), 32'(edout));
    check({tag, " Busy"}, 32'(Busy), 32'(ebusy));
    @(posedge Clock); #1;
    ProcDone = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [8:0] d);
    WrEn = 1'b1; WrAddr = a; WrData = d;
    @(posedge Clock); #1;
    WrEn = 1'b0;
  endtask

  task automatic do_start();
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
  endtask

  task automatic load_p1();
    wr(5'd0, 9'o100);
    wr(5'd1, 9'd5);
    wr(5'd2, 9'o110);
    wr(5'd3, 9'd3);
    wr(5'd4, 9'o201);
  endtask

  task automatic run_p1(input string tag);
    LastAddr = 5'd4;
    do_start();
    check({tag, " halted cleared"}, 32'(Halted), 32'd0);
    check({tag, " count cleared"}, 32'(InstrCount), 32'd0);
    step(1'b0, 1'b1, 9'o100, 1'b1, {tag, " c1"});
    step(1'b1, 1'b0, 9'd5,   1'b1, {tag, " c2"});
    step(1'b0, 1'b1, 9'o110, 1'b1, {tag, " c3"});
    step(1'b1, 1'b0, 9'd3,   1'b1, {tag, " c4"});
    check({tag, " count2"}, 32'(InstrCount), 32'd2);
    step(1'b0, 1'b1, 9'o201, 1'b1, {tag, " c5"});
    step(1'b0, 1'b0, 9'd0,   1'b1, {tag, " c6"});
    step(1'b0, 1'b0, 9'd0,   1'b1, {tag, " c7"});
    step(1'b1, 1'b0, 9'd0,   1'b1, {tag, " c8"});
    check({tag, " halted"}, 32'(Halted), 32'd1);
    check({tag, " count3"}, 32'(InstrCount), 32'd3);
    check({tag, " idle busy"}, 32'(Busy), 32'd0);
    check({tag, " idle run"}, 32'(Run), 32'd0);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    Resetn = 1'b1; Start = 1'b0; LastAddr = '0; WrEn = 1'b0;
    WrAddr = '0; WrData = '0; ProcDone = 1'b0; Step = 1'b0;

    // Asynchronous reset before any clock edge.
    #1 Resetn = 1'b0;
    #1;
    check("rst Run", 32'(Run), 32'd0);
    check("rst DOUT", 32'(DOUT), 32'd0);
    check("rst Busy", 32'(Busy), 32'd0);
    check("rst Halted", 32'(Halted), 32'd0);
    check("rst InstrCount", 32'(InstrCount), 32'd0);
    #1 Resetn = 1'b1;
    @(posedge Clock); #1;

    load_p1();
    run_p1("p1");

    // mv at LastAddr=0, written in the same cycle Start is accepted.
    LastAddr = 5'd0;
    WrEn = 1'b1; WrAddr = 5'd0; WrData = 9'o020; Start = 1'b1;
    @(posedge Clock); #1;
    WrEn = 1'b0; Start = 1'b0;
    check("mv halted cleared", 32'(Halted), 32'd0);
    step(1'b0, 1'b1, 9'o020, 1'b1, "mv c1");
    step(1'b1, 1'b0, 9'd0,   1'b1, "mv c2");
    check("mv halted", 32'(Halted), 32'd1);
    check("mv count", 32'(InstrCount), 32'd1);
    check("mv busy", 32'(Busy), 32'd0);

    // mvi at address 31 wraps its data fetch to address 0.
    wr(5'd0, 9'd7);
    for (int a = 1; a <= 30; a++) wr(5'(a), 9'o020);
    wr(5'd31, 9'o100);
    LastAddr = 5'd31;
    do_start();
    for (int i = 0; i <= 30; i++) begin
      step(1'b0, 1'b1, (i == 0) ? 9'd7 : 9'o020, 1'b1, "wrap mv issue");
      step(1'b1, 1'b0, 9'd0, 1'b1, "wrap mv wait");
    end
    step(1'b0, 1'b1, 9'o100, 1'b1, "wrap mvi issue");
    step(1'b1, 1'b0, 9'd7,   1'b1, "wrap mvi data");
    check("wrap halted", 32'(Halted), 32'd1);
    check("wrap count", 32'(InstrCount), 32'd32);

    // Writes and Start while busy are ignored; reset mid-WAIT keeps memory.
    load_p1();
    LastAddr = 5'd4;
    do_start();
    Start = 1'b1; WrEn = 1'b1; WrAddr = 5'd2; WrData = 9'o777;
    step(1'b0, 1'b1, 9'o100, 1'b1, "busy c1");
    step(1'b1, 1'b0, 9'd5,   1'b1, "busy c2");
    Start = 1'b0; WrEn = 1'b0;
    step(1'b0, 1'b1, 9'o110, 1'b1, "busy c3");
    step(1'b1, 1'b0, 9'd3,   1'b1, "busy c4");
    step(1'b0, 1'b1, 9'o201, 1'b1, "busy c5");
    Resetn = 1'b0;
    #1;
    check("midrst Run", 32'(Run), 32'd0);
    check("midrst Busy", 32'(Busy), 32'd0);
    check("midrst DOUT", 32'(DOUT), 32'd0);
    check("midrst count", 32'(InstrCount), 32'd0);
    #1 Resetn = 1'b1;
    @(posedge Clock); #1;
    run_p1("rerun");

`ifdef FEEDER_SINGLE_STEP_EN
    wr(5'd0, 9'o020); wr(5'd1, 9'o020); wr(5'd2, 9'o020);
    LastAddr = 5'd2;
    do_start();
    step(1'b0, 1'b1, 9'o020, 1'b1, "ss i0");
    step(1'b1, 1'b0, 9'd0,   1'b1, "ss w0");
    step(1'b0, 1'b0, 9'd0,   1'b1, "ss hold0");
    step(1'b0, 1'b0, 9'd0,   1'b1, "ss hold1");
    check("ss count1", 32'(InstrCount), 32'd1);
    Step = 1'b1;
    step(1'b0, 1'b0, 9'd0,   1'b1, "ss go1");
    Step = 1'b0;
    step(1'b0, 1'b1, 9'o020, 1'b1, "ss i1");
    step(1'b1, 1'b0, 9'd0,   1'b1, "ss w1");
    step(1'b0, 1'b0, 9'd0,   1'b1, "ss hold2");
    Step = 1'b1;
    step(1'b0, 1'b0, 9'd0,   1'b1, "ss go2");
    Step = 1'b0;
    step(1'b0, 1'b1, 9'o020, 1'b1, "ss i2");
    step(1'b1, 1'b0, 9'd0,   1'b1, "ss w2");
    check("ss halted", 32'(Halted), 32'd1);
    check("ss count3", 32'(InstrCount), 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
